// File: rtl/uart_fmt_pkg.sv
// uart_fmt_pkg
// Shared definitions for the UART line formatter: FSM state encoding,
// ASCII constants and the channel-ID to type/unit character maps.
// No ports (package).
package uart_fmt_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_CONVERT     = 4'd1,
    S_SEND_TYPE   = 4'd2,
    S_SEND_COLON  = 4'd3,
    S_SEND_SIGN   = 4'd4,
    S_SEND_DIGITS = 4'd5,
    S_SEND_UNIT   = 4'd6,
    S_SEND_CR     = 4'd7,
    S_SEND_LF     = 4'd8
  } state_t;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] QMARK = 8'h3F;

  // Type character leading each line: V, T, B, A, R, else '?'.
  function automatic logic [7:0] id_to_type_char(input logic [31:0] id);
    logic [7:0] c;
    case (id)
      32'd0:   c = 8'h56;
      32'd1:   c = 8'h54;
      32'd2:   c = 8'h42;
      32'd3:   c = 8'h41;
      32'd4:   c = 8'h52;
      default: c = QMARK;
    endcase
    return c;
  endfunction

  // Unit character trailing the digits: m, C, #, #, s, else space.
  function automatic logic [7:0] id_to_unit_char(input logic [31:0] id);
    logic [7:0] c;
    case (id)
      32'd0:   c = 8'h6D;
      32'd1:   c = 8'h43;
      32'd2:   c = 8'h23;
      32'd3:   c = 8'h23;
      32'd4:   c = 8'h73;
      default: c = SPACE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Iterative double-dabble (shift-add-3) converter, one input bit per cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : load bin and begin a conversion (ignored otherwise)
//   bin        : unsigned binary input, sampled on start
//   busy       : conversion in progress
//   done       : 1-cycle pulse during the final shift; bcd/ovf are final
//                after that clock edge
//   bcd        : NUM_DIGITS packed BCD digits, most significant at the top
//   ovf        : sticky, set when a 1 shifts out of the top BCD digit
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  adj;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [5:0]        cnt_q, cnt_d;

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign done = busy_q && (cnt_q == 6'(DATA_W - 1));

  always_comb begin
    sr_d   = sr_q;
    bcd_d  = bcd_q;
    ovf_d  = ovf_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start) begin
      sr_d   = bin;
      bcd_d  = '0;
      ovf_d  = 1'b0;
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      bcd_d = {adj[BCD_W-2:0], sr_q[DATA_W-1]};
      sr_d  = {sr_q[DATA_W-2:0], 1'b0};
      // Top bit leaving the BCD register means value >= 10^NUM_DIGITS.
      ovf_d = ovf_q | adj[BCD_W-1];
      cnt_d = cnt_q + 6'd1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/uart_formatter_gen.sv
// uart_formatter_gen
// Turns one AXI4-Stream sample into an ASCII line on a UART byte stream:
//   <type> ':' [sign] <digits> <unit> CR LF
// Decimal (unsigned or signed) or hex, with '*' digits on decimal overflow.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   s_axis_tdata   : sample, only [DATA_W-1:0] used
//   s_axis_tid     : channel ID, picks type and unit characters
//   s_axis_tuser   : [0] signed decimal, [1] hex (hex wins)
//   s_axis_tvalid  : sample valid
//   s_axis_tready  : high only while idle
//   uart_tdata     : ASCII byte (space while idle)
//   uart_tvalid    : byte valid
//   uart_tready    : UART accepts byte
//   busy           : formatter not idle
// Handshake rule (both interfaces): a transfer happens on a clock edge where
// valid and ready are both high; a producer holds valid and data stable
// until that edge, and valid never depends on ready.
module uart_formatter_gen
  import uart_fmt_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5,
  parameter int ID_W       = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     s_axis_tdata,
  input  logic [ID_W-1:0] s_axis_tid,
  input  logic [1:0]      s_axis_tuser,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [7:0]      uart_tdata,
  output logic            uart_tvalid,
  input  logic            uart_tready,
  output logic            busy
);

  localparam int HEX_DIGITS = (DATA_W + 3) / 4;
  localparam int HEX_W      = 4 * HEX_DIGITS;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic              neg_q, neg_d;
  logic              sgn_q, sgn_d;   // signed decimal: sign byte is sent
  logic              hex_q, hex_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        unit_q, unit_d;

  logic [DATA_W-1:0] in_data, in_mag;
  logic              in_neg, accept, cvt_start, hs;
  logic              cvt_done, cvt_ovf, cvt_unused_busy;
  logic [BCD_W-1:0]  cvt_bcd, bcd_sh;
  logic [HEX_W-1:0]  hex_sh;
  logic [3:0]        dec_nib, hex_nib, last_idx;
  logic [7:0]        digit_char;

  if (DATA_W < 32) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^s_axis_tdata[31:DATA_W];
  end

  assign s_axis_tready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign hs            = uart_tvalid && uart_tready;

  // Magnitude in DATA_W unsigned bits; the most negative value maps to
  // 2^(DATA_W-1) exactly.
  always_comb begin
    in_data = s_axis_tdata[DATA_W-1:0];
    in_neg  = s_axis_tuser[0] && !s_axis_tuser[1] && in_data[DATA_W-1];
    in_mag  = in_neg ? ('0 - in_data) : in_data;
  end

  // The converter loads on the accept edge so decimal conversion fits in
  // DATA_W cycles of CONVERT.
  assign cvt_start = accept && !s_axis_tuser[1];

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bcd (
    .clk  (clk),
    .reset(reset),
    .start(cvt_start),
    .bin  (in_mag),
    .busy (cvt_unused_busy),
    .done (cvt_done),
    .bcd  (cvt_bcd),
    .ovf  (cvt_ovf)
  );

  // Digit selection, most significant digit at index 0.
  always_comb begin
    bcd_sh  = cvt_bcd >> (4 * (NUM_DIGITS - 1 - int'(idx_q)));
    hex_sh  = HEX_W'(mag_q) >> (4 * (HEX_DIGITS - 1 - int'(idx_q)));
    dec_nib = bcd_sh[3:0];
    hex_nib = hex_sh[3:0];
    if (hex_q) begin
      digit_char = (hex_nib < 4'd10) ? (ZERO + {4'h0, hex_nib})
                                     : (8'h37 + {4'h0, hex_nib});
    end else if (cvt_ovf) begin
      digit_char = STAR;
    end else begin
      digit_char = ZERO + {4'h0, dec_nib};
    end
  end

  assign last_idx = hex_q ? 4'(HEX_DIGITS - 1) : 4'(NUM_DIGITS - 1);

  // Output byte is a pure function of state, index and latches, so it stays
  // stable while the UART stalls.
  always_comb begin
    uart_tvalid = 1'b1;
    uart_tdata  = SPACE;
    case (state_q)
      S_SEND_TYPE:   uart_tdata = type_q;
      S_SEND_COLON:  uart_tdata = COLON;
      S_SEND_SIGN:   uart_tdata = neg_q ? MINUS : PLUS;
      S_SEND_DIGITS: uart_tdata = digit_char;
      S_SEND_UNIT:   uart_tdata = unit_q;
      S_SEND_CR:     uart_tdata = CR;
      S_SEND_LF:     uart_tdata = LF;
      default:       uart_tvalid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    hex_d   = hex_q;
    type_d  = type_q;
    unit_d  = unit_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mag_d   = in_mag;
          neg_d   = in_neg;
          sgn_d   = s_axis_tuser[0] && !s_axis_tuser[1];
          hex_d   = s_axis_tuser[1];
          type_d  = id_to_type_char(32'(s_axis_tid));
          unit_d  = id_to_unit_char(32'(s_axis_tid));
          idx_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT:    if (hex_q || cvt_done) state_d = S_SEND_TYPE;
      S_SEND_TYPE:  if (hs) state_d = S_SEND_COLON;
      S_SEND_COLON: begin
        if (hs) begin
          idx_d   = '0;
          state_d = sgn_q ? S_SEND_SIGN : S_SEND_DIGITS;
        end
      end
      S_SEND_SIGN:  if (hs) state_d = S_SEND_DIGITS;
      S_SEND_DIGITS: begin
        if (hs) begin
          if (idx_q == last_idx) state_d = S_SEND_UNIT;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      S_SEND_UNIT:  if (hs) state_d = S_SEND_CR;
      S_SEND_CR:    if (hs) state_d = S_SEND_LF;
      S_SEND_LF:    if (hs) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      hex_q   <= 1'b0;
      type_q  <= '0;
      unit_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      hex_q   <= hex_d;
      type_q  <= type_d;
      unit_q  <= unit_d;
    end
  end

endmodule

// File: tb/tb_uart_formatter_gen.sv
module tb_uart_formatter_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- stimulus and DUT wiring ----------------
  logic [31:0] s_tdata;
  logic [2:0]  s_tid;
  logic [1:0]  s_tuser;
  logic        s_tvalid;
  logic        tb_uart_tready;
  logic        sel;  // 0: NUM_DIGITS=5 instance, 1: NUM_DIGITS=4 instance

  logic       a_tready, a_uvalid, a_busy, a_uready;
  logic [7:0] a_udata;
  logic       b_tready, b_uvalid, b_busy, b_uready;
  logic [7:0] b_udata;
  logic       m_tready, m_uvalid, m_busy;
  logic [7:0] m_udata;

  assign a_uready = sel ? 1'b1 : tb_uart_tready;
  assign b_uready = sel ? tb_uart_tready : 1'b1;
  assign m_tready = sel ? b_tready : a_tready;
  assign m_uvalid = sel ? b_uvalid : a_uvalid;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_udata  = sel ? b_udata  : a_udata;

  uart_formatter_gen #(.DATA_W(16), .NUM_DIGITS(5), .ID_W(3)) dut_a (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tid(s_tid), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready),
    .uart_tdata(a_udata), .uart_tvalid(a_uvalid), .uart_tready(a_uready),
    .busy(a_busy)
  );

  uart_formatter_gen #(.DATA_W(16), .NUM_DIGITS(4), .ID_W(3)) dut_b (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tid(s_tid), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready),
    .uart_tdata(b_udata), .uart_tvalid(b_uvalid), .uart_tready(b_uready),
    .busy(b_busy)
  );

  // ---------------- scoreboard ----------------
  int         checks;
  int         failures;
  int         rdy_cnt;
  logic [7:0] exp_q[$];

  // Sample presented at the first negedge after an accept (back-to-back).
  logic        nxt_valid;
  logic [31:0] nxt_data;
  logic [2:0]  nxt_id;
  logic [1:0]  nxt_user;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic step();
    @(negedge clk);
    if (m_tready === 1'b1) rdy_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  // Returns at a negedge where the selected DUT is ready: the next posedge
  // is the accept edge.
  task automatic send_sample(input logic [31:0] d, input logic [2:0] id, input logic [1:0] u);
    int n;
    n = 0;
    @(negedge clk);
    s_tdata  = d;
    s_tid    = id;
    s_tuser  = u;
    s_tvalid = 1'b1;
    while (m_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
  endtask

  // Called right before the accept edge. Checks first-byte latency (edges
  // after accept at which the first byte can transfer), then the bytes in
  // exp_q. n_stop>0 stops after that many bytes; otherwise the idle state
  // after LF is checked.
  task automatic collect_frame(input int lat, input bit stall, input int n_stop);
    int k;
    int nb;
    int w;
    logic [7:0] e;
    logic [7:0] held;
    k  = 0;
    nb = 0;
    do begin
      step();
      k++;
      if (k == 1) begin
        s_tvalid = nxt_valid;
        if (nxt_valid) begin
          s_tdata = nxt_data;
          s_tid   = nxt_id;
          s_tuser = nxt_user;
        end else begin
          s_tdata = 32'hDEAD_BEEF;  // must be ignored outside IDLE
          s_tid   = 3'd7;
          s_tuser = 2'b11;
        end
      end
    end while (m_uvalid !== 1'b1 && k < 100);
    check("first_valid_latency", 32'(k), 32'(lat));
    while (exp_q.size() > 0 && (n_stop == 0 || nb < n_stop)) begin
      w = 0;
      while (m_uvalid !== 1'b1 && w < 50) begin
        step();
        w++;
      end
      e = exp_q.pop_front();
      if (stall) begin
        tb_uart_tready = 1'b0;
        held = m_udata;
        repeat (5) begin
          step();
          check("stall_hold", {23'd0, m_uvalid, m_udata}, {23'd0, 1'b1, held});
        end
        tb_uart_tready = 1'b1;
      end
      check("byte", {24'd0, m_udata}, {24'd0, e});
      nb++;
      step();
    end
    if (n_stop == 0) begin
      check("idle_uvalid", {31'd0, m_uvalid}, 32'd0);
      check("idle_tready", {31'd0, m_tready}, 32'd1);
      check("idle_busy",   {31'd0, m_busy},   32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        sel;
    logic [2:0]  id;
    logic [1:0]  user;
    logic [31:0] data;
    logic [7:0]  lat;
    logic        stall;
  } vec_t;

  localparam int NV = 13;
  vec_t  tab[NV];
  string tab_s[NV];

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks = 0; failures = 0; rdy_cnt = 0;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tid = '0; s_tuser = '0;
    tb_uart_tready = 1'b1; sel = 1'b0;
    nxt_valid = 1'b0; nxt_data = '0; nxt_id = '0; nxt_user = '0;

    tab[0]  = '{1'b0, 3'd0, 2'b00, 32'd1234,       8'd17, 1'b0}; tab_s[0]  = "V:01234m";
    tab[1]  = '{1'b0, 3'd1, 2'b01, 32'h0000_FFFF,  8'd17, 1'b0}; tab_s[1]  = "T:-00001C";
    tab[2]  = '{1'b0, 3'd1, 2'b01, 32'h0000_8000,  8'd17, 1'b0}; tab_s[2]  = "T:-32768C";
    tab[3]  = '{1'b0, 3'd1, 2'b00, 32'h0000_FFFF,  8'd17, 1'b0}; tab_s[3]  = "T:65535C";
    tab[4]  = '{1'b0, 3'd2, 2'b10, 32'h0000_BEEF,  8'd2,  1'b0}; tab_s[4]  = "B:BEEF#";
    tab[5]  = '{1'b0, 3'd2, 2'b11, 32'h0000_BEEF,  8'd2,  1'b0}; tab_s[5]  = "B:BEEF#";
    tab[6]  = '{1'b0, 3'd1, 2'b01, 32'd100,        8'd17, 1'b0}; tab_s[6]  = "T:+00100C";
    tab[7]  = '{1'b0, 3'd4, 2'b00, 32'hABCD_0007,  8'd17, 1'b0}; tab_s[7]  = "R:00007s";
    tab[8]  = '{1'b0, 3'd0, 2'b01, 32'h0000_FC18,  8'd17, 1'b0}; tab_s[8]  = "V:-01000m";
    tab[9]  = '{1'b0, 3'd0, 2'b00, 32'd42,         8'd17, 1'b1}; tab_s[9]  = "V:00042m";
    tab[10] = '{1'b1, 3'd3, 2'b00, 32'd12345,      8'd17, 1'b0}; tab_s[10] = "A:****#";
    tab[11] = '{1'b1, 3'd3, 2'b00, 32'd9999,       8'd17, 1'b0}; tab_s[11] = "A:9999#";
    tab[12] = '{1'b1, 3'd6, 2'b10, 32'h0000_0FFF,  8'd2,  1'b0}; tab_s[12] = "?:0FFF ";

    // Reset values, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_a_tready", {31'd0, a_tready}, 32'd1);
    check("rst_a_uvalid", {31'd0, a_uvalid}, 32'd0);
    check("rst_a_udata",  {24'd0, a_udata},  32'h20);
    check("rst_a_busy",   {31'd0, a_busy},   32'd0);
    check("rst_b_udata",  {24'd0, b_udata},  32'h20);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tready", {31'd0, a_tready}, 32'd1);
    check("post_rst_uvalid", {31'd0, a_uvalid}, 32'd0);

    // Table-driven frames.
    for (int v = 0; v < NV; v++) begin
      if (v > 0 && tab[v].sel != tab[v-1].sel) repeat (40) @(negedge clk);
      sel = tab[v].sel;
      exp_q.delete();
      load_exp(tab_s[v]);
      send_sample(tab[v].data, tab[v].id, tab[v].user);
      collect_frame(int'(tab[v].lat), tab[v].stall, 0);
    end

    // Reset in the middle of the digit bytes.
    repeat (40) @(negedge clk);
    sel = 1'b0;
    exp_q.delete();
    load_exp("V:01234m");
    send_sample(32'd1234, 3'd0, 2'b00);
    collect_frame(17, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_uvalid", {31'd0, a_uvalid}, 32'd0);
    check("midrst_udata",  {24'd0, a_udata},  32'h20);
    check("midrst_tready", {31'd0, a_tready}, 32'd1);
    check("midrst_busy",   {31'd0, a_busy},   32'd0);
    reset = 1'b0;
    exp_q.delete();
    load_exp("T:+00100C");
    send_sample(32'd100, 3'd1, 2'b01);
    collect_frame(17, 1'b0, 0);

    // Back-to-back: tvalid held high, second sample waiting during frame 1.
    repeat (5) @(negedge clk);
    exp_q.delete();
    load_exp("R:00500s");
    nxt_valid = 1'b1; nxt_data = 32'd7; nxt_id = 3'd5; nxt_user = 2'b00;
    send_sample(32'd500, 3'd4, 2'b00);
    rdy_cnt = 0;
    collect_frame(17, 1'b0, 0);
    check("b2b_ready_cycles", 32'(rdy_cnt), 32'd1);
    nxt_valid = 1'b0;
    exp_q.delete();
    load_exp("?:00007 ");
    collect_frame(17, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
